// File: rtl/instr_fetch.sv
// instr_fetch -- instruction fetch sequencer between an 8-bit-addressed
// instruction memory and a CPU that uses a load/start/wait handshake.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   reset      : synchronous active-low reset
//   run        : level enable, sampled in IDLE and at instruction completion
//   mem_addr   : instruction memory address (always equals pc)
//   mem_rd     : memory read strobe (FETCH only)
//   mem_rdata  : memory read data, valid the cycle after mem_rd
//   cpu_in     : instruction word to the CPU instruction register (= ir)
//   cpu_load   : CPU instruction-register load enable (one cycle)
//   cpu_s      : CPU start pulse (one cycle)
//   cpu_w      : CPU waiting/idle flag, 1 = instruction finished
//   br_valid   : redirect request, honoured only while executing
//   br_target  : redirect address
//   pc         : current program counter
//   halted     : high while stopped on a halt instruction
//   icount     : saturating count of completed instructions
module instr_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [2:0] HALT_OP  = 3'b111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [7:0]  mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    output logic [15:0] cpu_in,
    output logic        cpu_load,
    output logic        cpu_s,
    input  logic        cpu_w,
    input  logic        br_valid,
    input  logic [7:0]  br_target,
    output logic [7:0]  pc,
    output logic        halted,
    output logic [15:0] icount
);

    typedef enum logic [2:0] {
        IDLE, FETCH, MEMWAIT, LOAD, START, EXEC, HALTED
    } state_t;

    state_t      state, state_nx;
    logic [15:0] ir;
    logic        exec_first;   // first EXEC cycle: cpu_w may still be stale
    logic        redir;
    logic [7:0]  redir_tgt;
    logic        done;

    assign mem_addr = pc;
    assign cpu_in   = ir;

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        mem_rd   = 1'b0;
        cpu_load = 1'b0;
        cpu_s    = 1'b0;
        halted   = 1'b0;
        case (state)
            IDLE:    if (run) state_nx = FETCH;
            FETCH: begin
                mem_rd   = 1'b1;
                state_nx = MEMWAIT;
            end
            MEMWAIT: state_nx = (mem_rdata[15:13] == HALT_OP) ? HALTED : LOAD;
            LOAD: begin
                cpu_load = 1'b1;
                state_nx = START;
            end
            START: begin
                cpu_s    = 1'b1;
                state_nx = EXEC;
            end
            EXEC: begin
                if (!exec_first && cpu_w) begin
                    done     = 1'b1;
                    state_nx = run ? FETCH : IDLE;
                end
            end
            HALTED:  halted = 1'b1;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ir         <= 16'h0000;
            icount     <= 16'h0000;
            redir      <= 1'b0;
            redir_tgt  <= 8'h00;
            exec_first <= 1'b0;
        end else begin
            state      <= state_nx;
            exec_first <= (state == START);
            if (state == MEMWAIT) ir <= mem_rdata;
            if (state == EXEC && br_valid) begin
                redir     <= 1'b1;
                redir_tgt <= br_target;
            end
            if (done) begin
                // a redirect arriving on the completing cycle still wins
                if (br_valid)   pc <= br_target;
                else if (redir) pc <= redir_tgt;
                else            pc <= pc + 8'd1;
                if (icount != 16'hFFFF) icount <= icount + 16'd1;
                redir <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by
// randomized run/cpu_w/br_valid/reset traffic, all compared every cycle
// against an instruction-level reference model.
module tb_instr_fetch;

    localparam logic [2:0] HALT_OP = 3'b111;

    logic        clk = 1'b0;
    logic        reset, run, cpu_w, br_valid;
    logic [7:0]  br_target;
    logic [15:0] mem_rdata;
    logic [7:0]  mem_addr, pc;
    logic        mem_rd, cpu_load, cpu_s, halted;
    logic [15:0] cpu_in, icount;

    logic [15:0] mem [0:255];

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: f is the cycle number of the current fetch, -1 if none
    int          cyc = 0;
    int          f   = -1;
    int          t0  = 0;
    logic [7:0]  m_pc;
    logic [15:0] m_icnt, m_ir;
    logic        m_halt, m_redir;
    logic [7:0]  m_tgt;

    instr_fetch dut (
        .clk(clk), .reset(reset), .run(run),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_s(cpu_s), .cpu_w(cpu_w),
        .br_valid(br_valid), .br_target(br_target),
        .pc(pc), .halted(halted), .icount(icount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        check("mem_rd",   mem_rd,   (f >= 0 && cyc == f));
        check("cpu_load", cpu_load, (f >= 0 && cyc == f + 2));
        check("cpu_s",    cpu_s,    (f >= 0 && cyc == f + 3));
        check("halted",   halted,   m_halt);
        check("mem_addr", mem_addr, m_pc);
        check("pc",       pc,       m_pc);
        check("icount",   icount,   m_icnt);
        check("cpu_in",   cpu_in,   m_ir);
    endtask

    // apply one cycle of inputs, advance the model, then check the new cycle
    task automatic step(input logic r, input logic rn, input logic w,
                        input logic bv, input logic [7:0] bt);
        reset = r; run = rn; cpu_w = w; br_valid = bv; br_target = bt;
        @(posedge clk);
        if (!r) begin
            m_pc = 8'h00; m_icnt = 16'h0; m_ir = 16'h0;
            m_halt = 1'b0; m_redir = 1'b0; m_tgt = 8'h00; f = -1;
        end else if (!m_halt) begin
            if (f < 0) begin
                if (rn) f = cyc + 1;
            end else if (cyc == f + 1) begin
                m_ir = mem[m_pc];
                if (m_ir[15:13] == HALT_OP) begin
                    m_halt = 1'b1;
                    f = -1;
                end
            end else if (cyc >= f + 4) begin
                if (bv) begin
                    m_redir = 1'b1;
                    m_tgt = bt;
                end
                if (cyc >= f + 5 && w) begin
                    m_pc = m_redir ? m_tgt : m_pc + 8'd1;
                    if (m_icnt != 16'hFFFF) m_icnt = m_icnt + 16'd1;
                    m_redir = 1'b0;
                    f = rn ? cyc + 1 : -1;
                end
            end
        end
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        t0 = cyc;
    endtask

    function automatic int rel();
        return cyc - t0;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    initial begin
        int seen;
        int hc;
        reset = 1'b0; run = 1'b0; cpu_w = 1'b0; br_valid = 1'b0; br_target = 8'h00;

        // basic fetch timing, then halt on the third word
        clear_mem();
        mem[0] = 16'hD105;
        mem[2] = 16'hE000;
        do_reset();
        check("rst_addr", mem_addr, 8'h00);
        check("rst_cpu_in", cpu_in, 16'h0000);
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
            if (rel() == 1) check("t1_rd_c1", mem_rd, 1'b1);
            if (rel() == 3) begin
                check("t1_load_c3", cpu_load, 1'b1);
                check("t1_in_c3", cpu_in, 16'hD105);
            end
            if (rel() == 4) check("t1_s_c4", cpu_s, 1'b1);
            if (rel() == 7) begin
                check("t1_pc_c7", pc, 8'h01);
                check("t1_icnt_c7", icount, 16'd1);
            end
            if (rel() >= 13 && cpu_load) seen++;
        end
        check("t1_halted", halted, 1'b1);
        check("t1_halt_pc", pc, 8'h02);
        check("t1_halt_icnt", icount, 16'd2);
        check("t1_no_load_halt", seen, 0);

        // slow CPU: cpu_w low for five cycles after cpu_s
        clear_mem();
        do_reset();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, rel() < 5, !(rel() >= 5 && rel() <= 9), 1'b0, 8'h00);
            if (mem_rd) seen++;
            if (rel() == 10) check("t2_pc_wait", pc, 8'h00);
        end
        check("t2_one_fetch", seen, 1);
        check("t2_pc", pc, 8'h01);
        check("t2_icnt", icount, 16'd1);

        // redirects, including one to 8'hFF followed by wrap to 8'h00
        clear_mem();
        mem[8'hFF] = 16'h1111;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            case (rel())
                5:       step(1'b1, 1'b1, 1'b0, 1'b1, 8'h40);
                11:      step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
                default: step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
            endcase
            if (rel() == 7) begin
                check("t3_rd_40", mem_rd, 1'b1);
                check("t3_addr_40", mem_addr, 8'h40);
            end
            if (rel() == 13) check("t3_addr_ff", mem_addr, 8'hFF);
            if (rel() == 19) begin
                check("t3_rd_wrap", mem_rd, 1'b1);
                check("t3_addr_wrap", mem_addr, 8'h00);
                check("t3_icnt", icount, 16'd3);
            end
        end

        // reset in EXEC with a redirect pending
        clear_mem();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            case (rel())
                5:       step(1'b1, 1'b1, 1'b0, 1'b1, 8'h80);
                6:       step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
                default: step(1'b1, rel() >= 7 || rel() < 5, 1'b1, 1'b0, 8'h00);
            endcase
            if (rel() == 7) begin
                check("t4_rd_idle", mem_rd, 1'b0);
                check("t4_pc", pc, 8'h00);
                check("t4_icnt", icount, 16'd0);
            end
            if (rel() == 14) begin
                check("t4_rd_next", mem_rd, 1'b1);
                check("t4_no_redir", mem_addr, 8'h01);
            end
        end

        // randomized traffic with occasional halts and resets
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            if (mem[i][15:13] == HALT_OP && $urandom_range(0, 3) != 0)
                mem[i][15:13] = 3'b000;
        end
        do_reset();
        hc = 0;
        for (int i = 0; i < 4000; i++) begin
            hc = m_halt ? hc + 1 : 0;
            step(!(hc > 8 || $urandom_range(0, 299) == 0),
                 $urandom_range(0, 7) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
